// File: rtl/instr_prefetch_decode_pkg.sv
// Shared definitions for the instruction prefetch/decode front end:
// fetch FSM states, the Beta opcode set and the opcode classification helpers.
package instr_prefetch_decode_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } fetch_state_t;

    typedef enum logic [5:0] {
        OP_EXIT   = 6'h00,
        OP_LD     = 6'h18, OP_ST     = 6'h19, OP_JMP    = 6'h1B,
        OP_BEQ    = 6'h1C, OP_BNE    = 6'h1D, OP_LDR    = 6'h1F,
        OP_ADD    = 6'h20, OP_SUB    = 6'h21, OP_MUL    = 6'h22, OP_DIV    = 6'h23,
        OP_CMPEQ  = 6'h24, OP_CMPLT  = 6'h25, OP_CMPLE  = 6'h26,
        OP_AND    = 6'h28, OP_OR     = 6'h29, OP_XOR    = 6'h2A, OP_XNOR   = 6'h2B,
        OP_SHL    = 6'h2C, OP_SHR    = 6'h2D, OP_SRA    = 6'h2E,
        OP_ADDC   = 6'h30, OP_SUBC   = 6'h31, OP_MULC   = 6'h32, OP_DIVC   = 6'h33,
        OP_CMPEQC = 6'h34, OP_CMPLTC = 6'h35, OP_CMPLEC = 6'h36,
        OP_ANDC   = 6'h38, OP_ORC    = 6'h39, OP_XORC   = 6'h3A, OP_XNORC  = 6'h3B,
        OP_SHLC   = 6'h3C, OP_SHRC   = 6'h3D, OP_SRAC   = 6'h3E
    } opcode_t;

    typedef struct packed {
        logic is_lit;
        logic is_alu;
        logic is_mem;
        logic is_branch;
        logic is_exit;
        logic illegal;
    } op_class_t;

    // True when the opcode is one of the defined Beta instructions.
    function automatic logic opcode_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_EXIT, OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR,
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMPEQ, OP_CMPLT, OP_CMPLE,
            OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SHL, OP_SHR, OP_SRA,
            OP_ADDC, OP_SUBC, OP_MULC, OP_DIVC, OP_CMPEQC, OP_CMPLTC, OP_CMPLEC,
            OP_ANDC, OP_ORC, OP_XORC, OP_XNORC, OP_SHLC, OP_SHRC, OP_SRAC:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Class flags seen by execute; the lit/alu flags are pure bit tests of the opcode.
    function automatic op_class_t opcode_class(input logic [5:0] op);
        op_class_t c;
        c.is_lit    = (op[5:4] == 2'b11);
        c.is_alu    = op[5];
        c.is_mem    = (op == OP_LD) || (op == OP_ST) || (op == OP_LDR);
        c.is_branch = (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE);
        c.is_exit   = (op == OP_EXIT);
        c.illegal   = ~opcode_legal(op);
        return c;
    endfunction

endpackage

// File: rtl/instr_prefetch_decode_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs, plus its overflow checker.
module sync_fifo_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Clear wins over both push and pop; popping an empty FIFO is ignored.
    assign push_s = push & ~clear;
    assign pop_s  = pop & ~clear & ~empty;
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign full   = (count_r == CNT_W'(DEPTH));
    assign rdata  = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    sync_fifo_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (full)
    );

endmodule

// File: rtl/instr_prefetch_decode.sv
// Fetch/decode front end: prefetches instruction words over req/ack into a FIFO
// and presents the decoded head to execute over valid/ready.
module instr_prefetch_decode
    import instr_prefetch_decode_pkg::*;
#(
    parameter int                INSTR_W  = 32,
    parameter int                REG_BITS = 5,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         flush_pc,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [INSTR_W-1:0]        mem_rdata,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [ADDR_W-1:0]         dec_pc,
    output logic [5:0]                dec_opcode,
    output logic [REG_BITS-1:0]       dec_rc,
    output logic [REG_BITS-1:0]       dec_ra,
    output logic [REG_BITS-1:0]       dec_rb,
    output logic [DATA_W-1:0]         dec_lit,
    output logic                      dec_is_lit,
    output logic                      dec_is_alu,
    output logic                      dec_is_mem,
    output logic                      dec_is_branch,
    output logic                      dec_exit,
    output logic                      dec_illegal,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int LIT_W  = INSTR_W - 6 - 2 * REG_BITS;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);

    fetch_state_t         state_r;
    logic [ADDR_W-1:0]    fetch_pc_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [ENTRY_W-1:0]   head_s;
    logic [INSTR_W-1:0]   head_word_s;
    op_class_t            cls_s;

    // Only a live WAIT_ACK ack is kept; a flush in the same cycle drops the word.
    assign push_s      = (state_r == WAIT_ACK) & mem_ack & ~flush;
    assign pop_s       = dec_valid & dec_ready;
    assign dec_valid   = ~fifo_empty_s;
    assign head_word_s = head_s[INSTR_W-1:0];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({fetch_pc_r, mem_rdata}),
        .rdata (head_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Fetch FSM: one outstanding request at most, redirect/drain on flush, halt after EXIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            fetch_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        fetch_pc_r <= flush_pc;
                    end else if (fifo_count < CNT_W'(DEPTH)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc_r;
                        state_r  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (flush) begin
                        fetch_pc_r <= flush_pc;
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        mem_req    <= 1'b0;
                        fetch_pc_r <= fetch_pc_r + PC_STEP;
                        if (mem_rdata[INSTR_W-1 -: 6] == OP_EXIT) begin
                            state_r <= HALT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    // The old request completes with its original address; the data is discarded.
                    if (flush) begin
                        fetch_pc_r <= flush_pc;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                HALT: begin
                    if (flush) begin
                        fetch_pc_r <= flush_pc;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Field extraction and classification of the FIFO head; everything reads 0 while empty.
    always_comb begin
        if (dec_valid) begin
            dec_pc     = head_s[ENTRY_W-1 -: ADDR_W];
            dec_opcode = head_word_s[INSTR_W-1 -: 6];
            dec_rc     = head_word_s[INSTR_W-7 -: REG_BITS];
            dec_ra     = head_word_s[INSTR_W-7-REG_BITS -: REG_BITS];
            dec_rb     = head_word_s[INSTR_W-7-2*REG_BITS -: REG_BITS];
            dec_lit    = {DATA_W{head_word_s[LIT_W-1]}};
            dec_lit[LIT_W-1:0] = head_word_s[LIT_W-1:0];
            cls_s      = opcode_class(head_word_s[INSTR_W-1 -: 6]);
        end else begin
            dec_pc     = {ADDR_W{1'b0}};
            dec_opcode = 6'b000000;
            dec_rc     = {REG_BITS{1'b0}};
            dec_ra     = {REG_BITS{1'b0}};
            dec_rb     = {REG_BITS{1'b0}};
            dec_lit    = {DATA_W{1'b0}};
            cls_s      = op_class_t'(6'b000000);
        end
    end

    assign dec_is_lit    = cls_s.is_lit;
    assign dec_is_alu    = cls_s.is_alu;
    assign dec_is_mem    = cls_s.is_mem;
    assign dec_is_branch = cls_s.is_branch;
    assign dec_exit      = cls_s.is_exit;
    assign dec_illegal   = cls_s.illegal;

endmodule

// File: tb/tb_instr_prefetch_decode.sv
// Self-checking bench for instr_prefetch_decode (default parameters).
module tb_instr_prefetch_decode;

    logic        clk = 1'b0;
    logic        reset, flush, mem_req, mem_ack, dec_valid, dec_ready;
    logic [31:0] flush_pc, mem_addr, mem_rdata, dec_pc, dec_lit;
    logic [5:0]  dec_opcode;
    logic [4:0]  dec_rc, dec_ra, dec_rb;
    logic        dec_is_lit, dec_is_alu, dec_is_mem, dec_is_branch, dec_exit, dec_illegal;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] imem [256];
    bit          manual = 1'b0;
    logic        manual_ack = 1'b0;
    int          ack_lat = 0;
    int          ack_count = 0;

    localparam logic [31:0] W_ADD = 32'h80611000;

    typedef struct {
        logic [31:0] word;
        logic [20:0] fields;  // {opcode, rc, ra, rb}
        logic [31:0] lit;
        logic [5:0]  flags;   // {lit, alu, mem, branch, exit, illegal}
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    instr_prefetch_decode dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_opcode(dec_opcode), .dec_rc(dec_rc), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .dec_lit(dec_lit), .dec_is_lit(dec_is_lit), .dec_is_alu(dec_is_alu),
        .dec_is_mem(dec_is_mem), .dec_is_branch(dec_is_branch), .dec_exit(dec_exit),
        .dec_illegal(dec_illegal), .fifo_count(fifo_count)
    );

    // Memory responder: drives ack 1 time unit after each falling edge.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h00000000;
        forever begin
            @(negedge clk);
            #1;
            mem_rdata = imem[mem_addr[9:2]];
            if (manual) begin
                mem_ack  = manual_ack;
                wait_cnt = 0;
                if (manual_ack && mem_req) ack_count++;
            end else if (mem_req) begin
                if (wait_cnt >= ack_lat) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    ack_count++;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!dec_valid && t < 50) begin @(negedge clk); t++; end
        if (!dec_valid) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got dec_valid=0 after 50 cycles, expected 1", name);
        end
    endtask

    task automatic wait_req(input string name);
        int t = 0;
        while (!mem_req && t < 50) begin @(negedge clk); t++; end
        if (!mem_req) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got mem_req=0 after 50 cycles, expected 1", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; dec_ready = 1'b0;
        manual = 1'b0; manual_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int base, t, reqs;
        vecs[0] = '{32'hC020FFFF, {6'h30, 5'd1,  5'd0,  5'd31}, 32'hFFFFFFFF, 6'b110000};
        vecs[1] = '{32'h80611000, {6'h20, 5'd3,  5'd1,  5'd2},  32'h00001000, 6'b010000};
        vecs[2] = '{32'h60A20004, {6'h18, 5'd5,  5'd2,  5'd0},  32'h00000004, 6'b001000};
        vecs[3] = '{32'h73E78000, {6'h1C, 5'd31, 5'd7,  5'd16}, 32'hFFFF8000, 6'b000100};
        vecs[4] = '{32'h9C000000, {6'h27, 5'd0,  5'd0,  5'd0},  32'h00000000, 6'b010001};
        vecs[5] = '{32'h00000000, {6'h00, 5'd0,  5'd0,  5'd0},  32'h00000000, 6'b000010};
        vecs[6] = '{32'h6C1F0000, {6'h1B, 5'd0,  5'd31, 5'd0},  32'h00000000, 6'b000100};
        vecs[7] = '{32'h7C000010, {6'h1F, 5'd0,  5'd0,  5'd0},  32'h00000010, 6'b001000};
        vecs[8] = '{32'h64000000, {6'h19, 5'd0,  5'd0,  5'd0},  32'h00000000, 6'b001000};
        vecs[9] = '{32'hFC000000, {6'h3F, 5'd0,  5'd0,  5'd0},  32'h00000000, 6'b110001};
        for (int i = 0; i < 256; i++) imem[i] = W_ADD;
        flush_pc = 32'h0;

        // Reset state
        reset = 1'b1; flush = 1'b0; dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_dec_opcode", dec_opcode, 0);
        check("rst_dec_lit", dec_lit, 0);
        check("rst_flags", {dec_is_lit, dec_is_alu, dec_is_mem, dec_is_branch, dec_exit, dec_illegal}, 0);
        reset = 1'b0;

        // Decode table
        for (int i = 0; i < 10; i++) begin
            imem[0] = vecs[i].word;
            ack_lat = 0;
            do_reset();
            wait_valid($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_fields", i), {dec_opcode, dec_rc, dec_ra, dec_rb}, vecs[i].fields);
            check($sformatf("vec%0d_lit", i), dec_lit, vecs[i].lit);
            check($sformatf("vec%0d_flags", i),
                  {dec_is_lit, dec_is_alu, dec_is_mem, dec_is_branch, dec_exit, dec_illegal}, vecs[i].flags);
            check($sformatf("vec%0d_pc", i), dec_pc, 0);
        end
        imem[0] = W_ADD;

        // ADDC R1,R0,-1 with ack one cycle after request, execute always ready
        imem[0] = 32'hC020FFFF;
        ack_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        wait_valid("addc_valid");
        check("addc_opcode", dec_opcode, 6'b110000);
        check("addc_rc_ra", {dec_rc, dec_ra}, {5'd1, 5'd0});
        check("addc_lit", dec_lit, 32'hFFFFFFFF);
        check("addc_is_lit", dec_is_lit, 1);
        check("addc_pc", dec_pc, 0);
        @(negedge clk);
        check("addc_next_req", {mem_req, mem_addr}, {1'b1, 32'h4});
        imem[0] = W_ADD;

        // Backpressure: FIFO fills to DEPTH, then one pop allows exactly one fetch
        ack_lat = 1;
        do_reset();
        base = ack_count;
        repeat (40) @(negedge clk);
        check("full_acks", ack_count - base, 4);
        check("full_count", fifo_count, 4);
        check("full_no_req", mem_req, 0);
        check("full_head_pc", dec_pc, 0);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("pop_acks", ack_count - base, 5);
        check("pop_count", fifo_count, 4);
        check("pop_no_req", mem_req, 0);
        check("pop_head_pc", dec_pc, 4);

        // Flush during WAIT_ACK, ack 3 cycles later: drain then refetch at 0x100
        imem[64] = 32'h60A20004;
        ack_lat = 3;
        do_reset();
        base = ack_count;
        wait_req("drain_first_req");
        flush = 1'b1; flush_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        check("drain_req_held", {mem_req, mem_addr}, {1'b1, 32'h0});
        check("drain_count", fifo_count, 0);
        t = 0;
        while (!(mem_req && mem_addr == 32'h100) && t < 30) begin @(negedge clk); t++; end
        check("drain_redirect", {mem_req, mem_addr}, {1'b1, 32'h100});
        check("drain_acks", ack_count - base, 1);
        check("drain_dropped", {dec_valid, fifo_count}, 0);
        wait_valid("drain_new_valid");
        check("drain_new_head", {dec_pc, 26'h0, dec_opcode}, {32'h100, 26'h0, 6'h18});

        // Flush coincident with ack and pop: nothing pushed, no drain
        imem[128] = 32'h73E78000;
        do_reset();
        manual = 1'b1;
        wait_req("coinc_req0");
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        check("coinc_first_push", fifo_count, 1);
        wait_req("coinc_req1");
        check("coinc_req1_addr", mem_addr, 32'h4);
        manual_ack = 1'b1; flush = 1'b1; flush_pc = 32'h200; dec_ready = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0; flush = 1'b0; dec_ready = 1'b0;
        check("coinc_cleared", {dec_valid, fifo_count}, 0);
        check("coinc_req_dropped", mem_req, 0);
        @(negedge clk);
        check("coinc_redirect", {mem_req, mem_addr}, {1'b1, 32'h200});
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        check("coinc_new_head", {dec_valid, dec_pc}, {1'b1, 32'h200});

        // EXIT at 0x8 halts fetch; flush to 0x20 resumes
        imem[2] = 32'h00000000;
        ack_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        t = 0;
        while (!(dec_valid && dec_exit) && t < 60) begin @(negedge clk); t++; end
        check("exit_seen", {dec_valid, dec_exit}, 2'b11);
        check("exit_pc", dec_pc, 32'h8);
        reqs = 0;
        repeat (15) begin @(negedge clk); if (mem_req) reqs++; end
        check("exit_no_fetch", reqs, 0);
        flush = 1'b1; flush_pc = 32'h20;
        @(negedge clk);
        flush = 1'b0;
        wait_req("exit_resume_req");
        check("exit_resume_addr", mem_addr, 32'h20);
        wait_valid("exit_resume_valid");
        check("exit_resume_pc", dec_pc, 32'h20);
        imem[2] = W_ADD;

        // Illegal opcode is delivered and fetch continues
        imem[0] = 32'h9C000000;
        ack_lat = 1;
        do_reset();
        dec_ready = 1'b1;
        wait_valid("ill_valid");
        check("ill_flags", {dec_illegal, dec_is_alu}, 2'b11);
        @(negedge clk);
        check("ill_continue", {mem_req, mem_addr}, {1'b1, 32'h4});
        imem[0] = W_ADD;

        // Reset during WAIT_ACK beats a simultaneous flush; late ack ignored
        do_reset();
        manual = 1'b1;
        wait_req("rst_wa_req0");
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        wait_req("rst_wa_req1");
        check("rst_wa_addr", mem_addr, 32'h4);
        reset = 1'b1; flush = 1'b1; flush_pc = 32'h300;
        @(negedge clk);
        check("rst_wa_idle", {mem_req, mem_addr}, {1'b0, 32'h0});
        check("rst_wa_count", fifo_count, 0);
        reset = 1'b0; flush = 1'b0; manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        check("rst_late_ack", {dec_valid, fifo_count}, 0);
        check("rst_wins_flush", {mem_req, mem_addr}, {1'b1, 32'h0});
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        check("rst_refetch", {dec_valid, dec_pc}, {1'b1, 32'h0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
